veh_sensor_cond: RTL and testbench
==================================

// Module: veh_sensor_cond
// PURPOSE
// - Conditions the raw vehicle-loop sensor and produces the clean `sen` request for the traffic-light controller FSM.
// - Synchronises the input, debounces it, and latches each vehicle arrival until the controller accepts it.
// - Arrivals during a light cycle are held, not lost.
// - Sits directly upstream of the controller; `dn_idle` is driven from it (curr_st == initial state).
// PARAMETERS
// - DEB_CYCLES  2500000  stable cycles needed to accept a level change (50 ms @ 50 MHz); >= 2
// - DEB_W       22       debounce counter width; must hold DEB_CYCLES-1
// - CNT_W       8        width of the arrival event counter
// PORTS
// - clk        in   1      system clock, 50 MHz
// - rst        in   1      reset, ACTIVE-LOW, ASYNCHRONOUS; everything clears on its falling edge
// - sen_raw    in   1      raw loop-detector input, asynchronous to clk, may bounce
// - dn_idle    in   1      1 = controller in its initial state and able to accept a request
// - sen        out  1      request to controller; 1 = vehicle waiting
// - sen_level  out  1      debounced sensor level
// - evt_cnt    out  CNT_W  count of debounced rising edges; saturates at all-ones
// BEHAVIOUR
// - Reset values: sen=0, sen_level=0, evt_cnt=0, sync FFs=0, deb_cnt=0, pend_flag=0, dn_idle_q=1, state=IDLE.
// - Sync: 2-FF chain sen_raw -> s0 -> s_sync; no logic between the FFs.
// - Debounce:
//   - s_sync == sen_level: deb_cnt <= 0.
//   - Otherwise deb_cnt increments each cycle.
//   - At deb_cnt == DEB_CYCLES-1: sen_level <= s_sync and deb_cnt <= 0.
//   - A glitch shorter than DEB_CYCLES cycles never changes sen_level.
//   - Latency from a sen_raw edge to sen_level: 2 + DEB_CYCLES cycles.
// - rise = sen_level & ~sen_level_q (1-cycle pulse). accept = dn_idle_q & ~dn_idle (controller left its initial state).
// - Request FSM (registered; sen is a registered output, 1 only in PEND):
//   - IDLE: rise -> PEND. This applies even if dn_idle=0; the request waits.
//   - PEND: accept -> SERVE with pend_flag <= 0. Further rises in PEND are merged (one request).
//   - SERVE: rise sets pend_flag.
//     - dn_idle=1 with pend_flag=1 (or rise in that same cycle): -> PEND.
//     - dn_idle=1 otherwise: -> IDLE.
//   - Encoding 2 bits; the unused code -> IDLE next cycle, with sen=0.
// - Simultaneous events:
//   - rise and accept in the same cycle in PEND -> SERVE, and the rise is merged (pend_flag stays 0).
//   - rise and dn_idle returning to 1 in the same cycle in SERVE -> PEND.
// - Reset mid-operation drops any pending request; sen falls asynchronously.
// - No combinational path from any input to any output.
// CONFIGURATION
// - SEN_EVT_CNT_EN defined:
//   - evt_cnt increments by 1 on every rise and saturates at 2^CNT_W-1 (no wrap).
//   - A rise at saturation leaves evt_cnt unchanged.
// - SEN_EVT_CNT_EN undefined:
//   - No counter flops; evt_cnt is tied to 0.
//   - Port list is unchanged; all other behaviour is identical.
// TESTING (sim with DEB_CYCLES=4)
// - Reset: rst=0 with sen_raw=1 -> sen=0, sen_level=0, evt_cnt=0. Release rst -> sen_level=1 after 6 cycles.
// - Bounce rejection: 3-cycle pulse on sen_raw -> sen_level stays 0, sen stays 0, evt_cnt=0.
// - Basic request: hold sen_raw=1 with dn_idle=1 -> sen=1 one cycle after sen_level rises.
//   Then drop dn_idle -> sen=0 the next cycle. Raise dn_idle -> state IDLE, sen stays 0.
// - Arrival during cycle: dn_idle=0 in SERVE, new debounced rise -> sen stays 0.
//   Raise dn_idle -> sen=1 next cycle.
// - Mid-op reset: assert rst while in PEND -> sen=0 immediately, asynchronously.
//   After release, with sen_raw stable 0 -> sen stays 0.
// - Saturation (SEN_EVT_CNT_EN, CNT_W=2): 5 clean pulses -> evt_cnt reads 1,2,3,3,3.
//   Without the macro -> evt_cnt=0 throughout.

Source files
------------

// File: rtl/veh_sensor_cond.sv
// veh_sensor_cond: synchronise, debounce and latch vehicle-loop arrivals into a request for the light controller
// Ports:
//   clk       in  system clock
//   rst       in  active-low asynchronous reset
//   sen_raw   in  raw loop-detector input, asynchronous, may bounce
//   dn_idle   in  1 = controller in its initial state, able to accept a request
//   sen       out request to controller, 1 = vehicle waiting (decoded from state register)
//   sen_level out debounced sensor level
//   evt_cnt   out saturating count of debounced rising edges
// Optional feature: define SEN_EVT_CNT_EN to build the event counter; otherwise evt_cnt is tied to 0.
module veh_sensor_cond #(
  parameter int DEB_CYCLES = 2500000,
  parameter int DEB_W      = 22,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sen_raw,
  input  logic             dn_idle,
  output logic             sen,
  output logic             sen_level,
  output logic [CNT_W-1:0] evt_cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, PEND = 2'b01, SERVE = 2'b10} st_e;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  st_e              st_q, st_d;
  logic             s0_q, sync_q, lvl_q, lvl_d, lvl_dly_q, dni_q, pend_q, pend_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             rise, accept;
  assign rise      = lvl_q & ~lvl_dly_q;
  assign accept    = dni_q & ~dn_idle;
  assign sen       = (st_q == PEND);
  assign sen_level = lvl_q;
  // Counter runs only while the synchronised input disagrees with the level; any agreement restarts it.
  always_comb begin
    lvl_d = lvl_q;
    deb_d = '0;
    if (sync_q != lvl_q) begin
      if (deb_q == DEB_MAX) lvl_d = sync_q;
      else deb_d = deb_q + 1'b1;
    end
  end
  // pend_flag only matters while serving; it remembers an arrival seen during the controller's cycle.
  always_comb begin
    st_d   = st_q;
    pend_d = 1'b0;
    case (st_q)
      IDLE:  st_d = rise ? PEND : IDLE;
      PEND:  st_d = accept ? SERVE : PEND;
      SERVE: begin
        pend_d = (pend_q | rise) & ~dn_idle;
        st_d   = dn_idle ? ((pend_q | rise) ? PEND : IDLE) : SERVE;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q      <= 1'b0;
      sync_q    <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      deb_q     <= '0;
      dni_q     <= 1'b1;
      pend_q    <= 1'b0;
      st_q      <= IDLE;
    end else begin
      s0_q      <= sen_raw;
      sync_q    <= s0_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      deb_q     <= deb_d;
      dni_q     <= dn_idle;
      pend_q    <= pend_d;
      st_q      <= st_d;
    end
  end
`ifdef SEN_EVT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d   = (rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign evt_cnt = cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign evt_cnt = '0;
`endif
endmodule

// File: tb/tb_veh_sensor_cond.sv
// tb_veh_sensor_cond: randomized check of veh_sensor_cond against a behavioural arrival/request model
module tb_veh_sensor_cond;
  localparam int DEB = 4;
  localparam int CW  = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sen_raw = 1'b0;
  logic          dn_idle = 1'b1;
  logic          sen, sen_level;
  logic [CW-1:0] evt_cnt;
  int total = 0;
  int bad   = 0;
  veh_sensor_cond #(.DEB_CYCLES(DEB), .DEB_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sen_raw(sen_raw), .dn_idle(dn_idle),
    .sen(sen), .sen_level(sen_level), .evt_cnt(evt_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  // Reference model: history window for the debounce, waiting/busy/held flags for the arrival handshake.
  bit m_s0, m_ss, m_lvl, m_lvlp, m_dnp, m_wait, m_busy, m_held;
  int m_cnt;
  bit hist[$];
  always @(posedge clk or negedge rst) begin : model
    bit r, a, all;
    if (!rst) begin
      m_s0 = 0; m_ss = 0; m_lvl = 0; m_lvlp = 0; m_dnp = 1;
      m_wait = 0; m_busy = 0; m_held = 0; m_cnt = 0;
      hist.delete();
    end else begin
      r = m_lvl & !m_lvlp;
      a = m_dnp & !dn_idle;
      if (m_wait) begin
        if (a) begin m_wait = 0; m_busy = 1; m_held = 0; end
      end else if (m_busy) begin
        m_held = m_held | r;
        if (dn_idle) begin m_busy = 0; m_wait = m_held; m_held = 0; end
      end else if (r) m_wait = 1;
      if (r && m_cnt < (1 << CW) - 1) m_cnt++;
      hist.push_back(m_ss);
      if (hist.size() > DEB) void'(hist.pop_front());
      all = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] == m_lvl) all = 0;
      m_lvlp = m_lvl;
      if (all) m_lvl = !m_lvl;
      m_dnp = dn_idle;
      m_ss = m_s0;
      m_s0 = sen_raw;
    end
  end
  function automatic int exp_evt(input int c);
`ifdef SEN_EVT_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction
  always @(negedge clk) if (rst) begin
    chk("sen", sen, m_wait);
    chk("sen_level", sen_level, m_lvl);
    chk("evt_cnt", evt_cnt, exp_evt(m_cnt));
  end
  int rh = 1, dh = 1;
  task automatic rnd_step();
    @(negedge clk);
    if (--rh <= 0) begin sen_raw = ~sen_raw; rh = $urandom_range(1, 12); end
    if (--dh <= 0) begin dn_idle = ~dn_idle; dh = $urandom_range(1, 25); end
  endtask
  initial begin
    bit found;
    sen_raw = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_sen", sen, 0);
    chk("rst_lvl", sen_level, 0);
    chk("rst_evt", evt_cnt, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_lvl", sen_level, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("lat5", sen_level, 0);
    @(negedge clk);
    chk("lat6", sen_level, 1);
    repeat (3000) rnd_step();
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      rnd_step();
      found = m_wait;
    end
    chk("pend_found", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_sen", sen, 0);
    chk("async_lvl", sen_level, 0);
    sen_raw = 1'b0;
    dn_idle = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_sen", sen, 0);
    sen_raw = 1'b1;
    repeat (3) @(negedge clk);
    sen_raw = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_lvl", sen_level, 0);
    chk("bounce_sen", sen, 0);
    chk("bounce_evt", evt_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      sen_raw = 1'b1;
      repeat (10) @(negedge clk);
      sen_raw = 1'b0;
      repeat (10) @(negedge clk);
      chk("sat", evt_cnt, exp_evt(k < 3 ? k : 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
